// File: rtl/cpu_trace_emitter_if.sv
// Handshake bundle between the CPU retire logic, the trace emitter and the character sink.
// The master side supplies records and sink-ready; the slave side is the emitter.
interface cpu_trace_emitter_if #(
  parameter int TIME_W = 14
);
  logic              in_valid;
  logic              in_ready;
  logic              in_kind;
  logic [TIME_W-1:0] in_time;
  logic [31:0]       in_pc;
  logic [4:0]        in_reg;
  logic [31:0]       in_addr;
  logic [31:0]       in_data;
  logic [7:0]        char;
  logic              char_valid;
  logic              char_ready;
  logic              frame_done;

  modport master (
    output in_valid, in_kind, in_time, in_pc, in_reg, in_addr, in_data, char_ready,
    input  in_ready, char, char_valid, frame_done
  );

  modport slave (
    input  in_valid, in_kind, in_time, in_pc, in_reg, in_addr, in_data, char_ready,
    output in_ready, char, char_valid, frame_done
  );
endinterface

// File: rtl/cpu_trace_emitter.sv
// Serialises one write-back record per handshake into an ASCII trace line:
//   ^<time>@<pc>: $<reg> <= <data>#   or   ^<time>@<pc>: *<addr> <= <data>#
module cpu_trace_emitter #(
  parameter bit UPPER_HEX = 1'b0,
  parameter int TIME_W    = 14
) (
  input logic               clk,
  input logic               reset,
  cpu_trace_emitter_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_HAT, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_TAG,
    S_DEST, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        kind_q, kind_d;
  logic [13:0] time_q, time_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  reg_q, reg_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  char_q, char_d;
  logic        char_valid_q, char_valid_d;
  logic        frame_done_q, frame_done_d;

  logic              adv;
  logic [31:0]       t_in;
  logic [3:0][3:0]   tdig;
  logic [2:0]        t_last;
  logic [3:0]        reg_tens, reg_ones;
  logic [7:0]        glyph;

  function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (UPPER_HEX ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.char       = char_q;
  assign bus.char_valid = char_valid_q;
  assign bus.frame_done = frame_done_q;

  assign adv  = char_valid_q & bus.char_ready;
  assign t_in = 32'(bus.in_time[TIME_W-1:0]);

  // Decimal digits of the latched (already clamped) timestamp, index 3 = thousands.
  always_comb begin
    tdig[3] = 4'(time_q / 14'd1000);
    tdig[2] = 4'((time_q / 14'd100) % 14'd10);
    tdig[1] = 4'((time_q / 14'd10) % 14'd10);
    tdig[0] = 4'(time_q % 14'd10);
    if (time_q >= 14'd1000)     t_last = 3'd3;
    else if (time_q >= 14'd100) t_last = 3'd2;
    else if (time_q >= 14'd10)  t_last = 3'd1;
    else                        t_last = 3'd0;
    reg_tens = 4'(reg_q / 5'd10);
    reg_ones = 4'(reg_q % 5'd10);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kind_d       = kind_q;
    time_d       = time_q;
    pc_d         = pc_q;
    reg_d        = reg_q;
    addr_d       = addr_q;
    data_d       = data_q;
    frame_done_d = 1'b0;

    if (state_q == S_IDLE) begin
      if (bus.in_valid) begin
        state_d = S_HAT;
        kind_d  = bus.in_kind;
        time_d  = (t_in > 32'd9999) ? 14'd9999 : t_in[13:0];
        pc_d    = bus.in_pc;
        reg_d   = bus.in_reg;
        addr_d  = bus.in_addr;
        data_d  = bus.in_data;
      end
    end else if (adv) begin
      case (state_q)
        S_HAT: begin
          state_d = S_TIME;
          cnt_d   = t_last;
        end
        S_TIME:  if (cnt_q == 3'd0) state_d = S_AT; else cnt_d = cnt_q - 3'd1;
        S_AT: begin
          state_d = S_PC;
          cnt_d   = 3'd7;
        end
        S_PC:    if (cnt_q == 3'd0) state_d = S_COLON; else cnt_d = cnt_q - 3'd1;
        S_COLON: state_d = S_SP1;
        S_SP1:   state_d = S_TAG;
        S_TAG: begin
          state_d = S_DEST;
          cnt_d   = kind_q ? 3'd7 : ((reg_q >= 5'd10) ? 3'd1 : 3'd0);
        end
        S_DEST:  if (cnt_q == 3'd0) state_d = S_SP2; else cnt_d = cnt_q - 3'd1;
        S_SP2:   state_d = S_LT;
        S_LT:    state_d = S_EQ;
        S_EQ:    state_d = S_SP3;
        S_SP3: begin
          state_d = S_DATA;
          cnt_d   = 3'd7;
        end
        S_DATA:  if (cnt_q == 3'd0) state_d = S_HASH; else cnt_d = cnt_q - 3'd1;
        S_HASH: begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The output register is loaded with the glyph of the next state, so char
  // is registered yet tracks the state with no extra latency.
  always_comb begin
    glyph = 8'h00;
    case (state_d)
      S_HAT:   glyph = 8'h5e;
      S_TIME:  glyph = 8'h30 + {4'h0, tdig[cnt_d[1:0]]};
      S_AT:    glyph = 8'h40;
      S_PC:    glyph = hex_ch(nib(pc_q, cnt_d));
      S_COLON: glyph = 8'h3a;
      S_SP1:   glyph = 8'h20;
      S_TAG:   glyph = kind_q ? 8'h2a : 8'h24;
      S_DEST:  glyph = kind_q ? hex_ch(nib(addr_q, cnt_d))
                              : (8'h30 + {4'h0, (cnt_d[0] ? reg_tens : reg_ones)});
      S_SP2:   glyph = 8'h20;
      S_LT:    glyph = 8'h3c;
      S_EQ:    glyph = 8'h3d;
      S_SP3:   glyph = 8'h20;
      S_DATA:  glyph = hex_ch(nib(data_q, cnt_d));
      S_HASH:  glyph = 8'h23;
      default: glyph = 8'h00;
    endcase
    char_d       = glyph;
    char_valid_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      kind_q       <= 1'b0;
      time_q       <= 14'd0;
      pc_q         <= 32'd0;
      reg_q        <= 5'd0;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      char_q       <= 8'h00;
      char_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kind_q       <= kind_d;
      time_q       <= time_d;
      pc_q         <= pc_d;
      reg_q        <= reg_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter: frame text, timing, stalls, mid-frame reset and hex case.
module tb_cpu_trace_emitter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cpu_trace_emitter_if #(.TIME_W(16)) bus ();
  cpu_trace_emitter_if #(.TIME_W(14)) bus_u ();

  cpu_trace_emitter #(.UPPER_HEX(1'b0), .TIME_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  cpu_trace_emitter #(.UPPER_HEX(1'b1), .TIME_W(14)) dut_u (
    .clk(clk), .reset(reset), .bus(bus_u)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one record at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input bit kind, input logic [15:0] t, input logic [31:0] pc,
                      input logic [4:0] rg, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.in_kind  = kind;
    bus.in_time  = t;
    bus.in_pc    = pc;
    bus.in_reg   = rg;
    bus.in_addr  = addr;
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_kind  = ~kind;
    bus.in_time  = 16'($urandom);
    bus.in_pc    = $urandom;
    bus.in_reg   = 5'($urandom);
    bus.in_addr  = $urandom;
    bus.in_data  = $urandom;
  endtask

  // Collects one frame starting at the current negedge (cycle 1 of the frame).
  task automatic capture(input bit toggle, input bit mess, output string s, output int fd_cycle,
                         output int fd_len, output int stall_bad, output int zero_bad,
                         output int rdy_bad, output bit valid_at_fd);
    int   c = 0;
    bit   done = 0;
    bit   held_v = 0;
    logic [7:0] held = 8'h00;
    bit   rdy;
    s = ""; fd_cycle = -1; fd_len = -1; stall_bad = 0; zero_bad = 0; rdy_bad = 0; valid_at_fd = 1;
    while (!done && c < 300) begin
      c++;
      if (held_v && (bus.char !== held || bus.char_valid !== 1'b1)) stall_bad++;
      if (bus.char_valid !== 1'b1 && bus.char !== 8'h00) zero_bad++;
      if (bus.frame_done === 1'b1) begin
        fd_cycle = c;
        fd_len = s.len();
        valid_at_fd = bus.char_valid;
        done = 1;
      end else begin
        if (bus.in_ready !== 1'b0) rdy_bad++;
        rdy = toggle ? c[0] : 1'b1;
        bus.char_ready = rdy;
        held_v = (bus.char_valid === 1'b1) && !rdy;
        held = bus.char;
        if (bus.char_valid === 1'b1 && rdy) s = {s, $sformatf("%c", bus.char)};
        if (mess && c == 5) begin
          bus.in_kind  = 1'b1;
          bus.in_time  = 16'd338;
          bus.in_pc    = 32'h0000_3130;
          bus.in_reg   = 5'd7;
          bus.in_addr  = 32'h0000_0088;
          bus.in_data  = 32'hffff_b528;
          bus.in_valid = 1'b1;
        end
        @(negedge clk);
      end
    end
    bus.char_ready = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.char_valid !== 1'b0 || bus.char !== 8'h00 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b char_valid=%b char=%h frame_done=%b, need 1 0 00 0",
               bus.in_ready, bus.char_valid, bus.char, bus.frame_done);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.char_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: in_ready=%b char_valid=%b, need 1 0", bus.in_ready, bus.char_valid);
    end
  endtask

  task automatic test_reg_write(input bit toggle);
    string s; int fdc, fdl, sb, zb, rb; bit vf;
    string exp = "^242@000030f4: $31 <= 12345678#";
    int exp_fd = toggle ? 62 : 32;
    send(1'b0, 16'd242, 32'h0000_30f4, 5'd31, 32'h0, 32'h1234_5678);
    capture(toggle, 1'b0, s, fdc, fdl, sb, zb, rb, vf);
    n_checks++;
    if (s != exp) begin
      n_fail++;
      $display("FAIL reg_write_text(toggle=%0d): got \"%s\" need \"%s\"", toggle, s, exp);
    end
    n_checks++;
    if (fdc != exp_fd || fdl != 31 || vf !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_write_done(toggle=%0d): frame_done cycle %0d after %0d chars valid=%b, need %0d after 31 valid=0",
               toggle, fdc, fdl, vf, exp_fd);
    end
    n_checks++;
    if (sb != 0 || zb != 0 || rb != 0) begin
      n_fail++;
      $display("FAIL reg_write_hold(toggle=%0d): stall_bad=%0d zero_bad=%0d in_ready_bad=%0d, need 0 0 0",
               toggle, sb, zb, rb);
    end
  endtask

  task automatic test_mem_write;
    string s; int fdc, fdl, sb, zb, rb; bit vf;
    string exp = "^338@00003130: *00000088 <= ffffb528#";
    send(1'b1, 16'd338, 32'h0000_3130, 5'd3, 32'h0000_0088, 32'hffff_b528);
    capture(1'b0, 1'b0, s, fdc, fdl, sb, zb, rb, vf);
    n_checks++;
    if (s != exp || fdc != 38) begin
      n_fail++;
      $display("FAIL mem_write: got \"%s\" done at %0d, need \"%s\" done at 38", s, fdc, exp);
    end
  endtask

  typedef struct {
    logic [15:0] t;
    logic [4:0]  rg;
    logic [31:0] pc;
    logic [31:0] data;
    string       exp;
  } vec_t;

  task automatic test_fields;
    vec_t v[6];
    string s; int fdc, fdl, sb, zb, rb; bit vf;
    v[0] = '{16'd0,     5'd0,  32'h0000_0001, 32'hdead_beef, "^0@00000001: $0 <= deadbeef#"};
    v[1] = '{16'd20000, 5'd5,  32'ha0b1_c2d3, 32'h0000_000f, "^9999@a0b1c2d3: $5 <= 0000000f#"};
    v[2] = '{16'd9,     5'd9,  32'h0,         32'h0,         "^9@00000000: $9 <= 00000000#"};
    v[3] = '{16'd10,    5'd10, 32'h0,         32'h0,         "^10@00000000: $10 <= 00000000#"};
    v[4] = '{16'd1000,  5'd5,  32'h0,         32'h0,         "^1000@00000000: $5 <= 00000000#"};
    v[5] = '{16'd10000, 5'd0,  32'h0,         32'h0,         "^9999@00000000: $0 <= 00000000#"};
    for (int i = 0; i < 6; i++) begin
      send(1'b0, v[i].t, v[i].pc, v[i].rg, 32'h5555_5555, v[i].data);
      capture(1'b0, 1'b0, s, fdc, fdl, sb, zb, rb, vf);
      n_checks++;
      if (s != v[i].exp || fdc != v[i].exp.len() + 1) begin
        n_fail++;
        $display("FAIL fields[%0d]: got \"%s\" done at %0d, need \"%s\" done at %0d",
                 i, s, fdc, v[i].exp, v[i].exp.len() + 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    string s; int fdc, fdl, sb, zb, rb; bit vf;
    string exp = "^0@00000001: $0 <= deadbeef#";
    send(1'b0, 16'd242, 32'h0000_30f4, 5'd31, 32'h0, 32'h1234_5678);
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.char !== 8'h32 || bus.char_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: char=%h valid=%b, need 32 1", bus.char, bus.char_valid);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.char_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.char !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_async: char_valid=%b in_ready=%b char=%h, need 0 1 00",
               bus.char_valid, bus.in_ready, bus.char);
    end
    @(negedge clk);
    reset = 1'b1;
    send(1'b0, 16'd0, 32'h0000_0001, 5'd0, 32'h0, 32'hdead_beef);
    capture(1'b0, 1'b0, s, fdc, fdl, sb, zb, rb, vf);
    n_checks++;
    if (s != exp || fdc != 29) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got \"%s\" done at %0d, need \"%s\" done at 29", s, fdc, exp);
    end
  endtask

  task automatic test_back_to_back;
    string s; int fdc, fdl, sb, zb, rb; bit vf;
    string exp_a = "^242@000030f4: $31 <= 12345678#";
    string exp_b = "^338@00003130: *00000088 <= ffffb528#";
    send(1'b0, 16'd242, 32'h0000_30f4, 5'd31, 32'h0, 32'h1234_5678);
    capture(1'b0, 1'b1, s, fdc, fdl, sb, zb, rb, vf);
    n_checks++;
    if (s != exp_a || fdc != 32 || rb != 0) begin
      n_fail++;
      $display("FAIL hold_midframe: got \"%s\" done at %0d in_ready_bad=%0d, need \"%s\" done at 32 with 0",
               s, fdc, rb, exp_a);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.char_valid !== 1'b1 || bus.char !== 8'h5e) begin
      n_fail++;
      $display("FAIL b2b_start: char_valid=%b char=%h one cycle after done, need 1 5e",
               bus.char_valid, bus.char);
    end
    capture(1'b0, 1'b0, s, fdc, fdl, sb, zb, rb, vf);
    n_checks++;
    if (s != exp_b || fdc != 38) begin
      n_fail++;
      $display("FAIL b2b_second: got \"%s\" done at %0d, need \"%s\" done at 38", s, fdc, exp_b);
    end
  endtask

  task automatic test_upper_hex;
    string s = "";
    string exp = "^9999@000030F4: *ABCDEF01 <= 0BADCAFE#";
    int c = 0;
    bit done = 0;
    @(negedge clk);
    bus_u.in_kind  = 1'b1;
    bus_u.in_time  = 14'd16383;
    bus_u.in_pc    = 32'h0000_30f4;
    bus_u.in_reg   = 5'd1;
    bus_u.in_addr  = 32'habcd_ef01;
    bus_u.in_data  = 32'h0bad_cafe;
    bus_u.in_valid = 1'b1;
    @(negedge clk);
    bus_u.in_valid = 1'b0;
    while (!done && c < 100) begin
      c++;
      if (bus_u.frame_done === 1'b1) done = 1;
      else begin
        if (bus_u.char_valid === 1'b1) s = {s, $sformatf("%c", bus_u.char)};
        @(negedge clk);
      end
    end
    n_checks++;
    if (s != exp || c != 39) begin
      n_fail++;
      $display("FAIL upper_hex: got \"%s\" done at %0d, need \"%s\" done at 39", s, c, exp);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_kind = 1'b0; bus.in_time = '0; bus.in_pc = '0;
    bus.in_reg = '0; bus.in_addr = '0; bus.in_data = '0; bus.char_ready = 1'b1;
    bus_u.in_valid = 1'b0; bus_u.in_kind = 1'b0; bus_u.in_time = '0; bus_u.in_pc = '0;
    bus_u.in_reg = '0; bus_u.in_addr = '0; bus_u.in_data = '0; bus_u.char_ready = 1'b1;
    test_reset;
    test_reg_write(1'b0);
    test_mem_write;
    test_fields;
    test_reg_write(1'b1);
    test_reset_mid;
    test_back_to_back;
    test_upper_hex;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
